// File: rtl/alu_pkg.sv
// ALU operation encoding and decoded select flags shared by the arbiter and decoder.
package alu_pkg;

    typedef enum logic [5:0] {
        ALU_ILLEGAL = 6'd0,
        ALU_AUIPC,
        ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
        ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
        ALU_SB, ALU_SH, ALU_SW,
        ALU_ADDI, ALU_SLTI, ALU_SLTIU, ALU_XORI, ALU_ORI, ALU_ANDI,
        ALU_SLLI, ALU_SRLI, ALU_SRAI,
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    localparam int ALU_OP_COUNT = 35;

    // One is_* flag per ALU function; use_imm picks the immediate as operand B.
    typedef struct packed {
        logic use_imm;
        logic is_add;
        logic is_sub;
        logic is_sll;
        logic is_slt;
        logic is_sltu;
        logic is_xor;
        logic is_srl;
        logic is_sra;
        logic is_or;
        logic is_and;
        logic is_beq;
        logic is_bne;
        logic is_blt;
        logic is_bge;
        logic is_bltu;
        logic is_bgeu;
        logic is_auipc;
        logic is_mem;
    } alu_sel_t;

endpackage

// File: rtl/alu_op_decode.sv
// Encoded alu_op_t to one-hot ALU select flags; unknown codes flag illegal.
module alu_op_decode
    import alu_pkg::*;
(
    input  alu_op_t  op,
    output alu_sel_t sel,
    output logic     illegal
);

    // Pure lookup: every legal op raises exactly one is_* flag.
    always_comb begin
        sel     = '0;
        illegal = 1'b0;
        case (op)
            ALU_AUIPC: begin sel.is_auipc = 1'b1; sel.use_imm = 1'b1; end
            ALU_BEQ:   sel.is_beq  = 1'b1;
            ALU_BNE:   sel.is_bne  = 1'b1;
            ALU_BLT:   sel.is_blt  = 1'b1;
            ALU_BGE:   sel.is_bge  = 1'b1;
            ALU_BLTU:  sel.is_bltu = 1'b1;
            ALU_BGEU:  sel.is_bgeu = 1'b1;
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW: begin sel.is_mem = 1'b1; sel.use_imm = 1'b1; end
            ALU_ADDI:  begin sel.is_add  = 1'b1; sel.use_imm = 1'b1; end
            ALU_SLTI:  begin sel.is_slt  = 1'b1; sel.use_imm = 1'b1; end
            ALU_SLTIU: begin sel.is_sltu = 1'b1; sel.use_imm = 1'b1; end
            ALU_XORI:  begin sel.is_xor  = 1'b1; sel.use_imm = 1'b1; end
            ALU_ORI:   begin sel.is_or   = 1'b1; sel.use_imm = 1'b1; end
            ALU_ANDI:  begin sel.is_and  = 1'b1; sel.use_imm = 1'b1; end
            ALU_SLLI:  begin sel.is_sll  = 1'b1; sel.use_imm = 1'b1; end
            ALU_SRLI:  begin sel.is_srl  = 1'b1; sel.use_imm = 1'b1; end
            ALU_SRAI:  begin sel.is_sra  = 1'b1; sel.use_imm = 1'b1; end
            ALU_ADD:   sel.is_add  = 1'b1;
            ALU_SUB:   sel.is_sub  = 1'b1;
            ALU_SLL:   sel.is_sll  = 1'b1;
            ALU_SLT:   sel.is_slt  = 1'b1;
            ALU_SLTU:  sel.is_sltu = 1'b1;
            ALU_XOR:   sel.is_xor  = 1'b1;
            ALU_SRL:   sel.is_srl  = 1'b1;
            ALU_SRA:   sel.is_sra  = 1'b1;
            ALU_OR:    sel.is_or   = 1'b1;
            ALU_AND:   sel.is_and  = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one combinational ALU between N_REQ requesters,
// with a registered response slot per requester.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int TAG_W = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req_valid,
    output logic [N_REQ-1:0]             req_ready,
    input  logic [N_REQ-1:0][5:0]        req_op,
    input  logic [N_REQ-1:0][31:0]       req_rs1,
    input  logic [N_REQ-1:0][31:0]       req_rs2,
    input  logic [N_REQ-1:0][31:0]       req_imm,
    input  logic [N_REQ-1:0][TAG_W-1:0]  req_tag,
    output logic [N_REQ-1:0]             rsp_valid,
    input  logic [N_REQ-1:0]             rsp_ready,
    output logic [N_REQ-1:0][31:0]       rsp_data,
    output logic [N_REQ-1:0][TAG_W-1:0]  rsp_tag,
    output logic [N_REQ-1:0]             rsp_err
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] elig;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] scan_idx;
    logic             gnt_any;

    alu_op_t          alu_op_p0;
    logic [31:0]      rs1_p0;
    logic [31:0]      rs2_p0;
    logic [31:0]      imm_p0;
    logic [31:0]      opb_p0;
    logic [4:0]       shamt_p0;
    logic [31:0]      alu_res_p0;
    alu_sel_t         sel_p0;
    logic             illegal_p0;

    // A requester may issue when its slot is empty or being drained this cycle.
    assign elig = req_valid & (~rsp_valid | rsp_ready);

    // Scan from rr_ptr upward (wrapping) and grant the first eligible requester.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        req_ready = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!gnt_any && elig[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (rst) gnt_any = 1'b0;
        if (gnt_any) req_ready[gnt_idx] = 1'b1;
    end

    // Operand mux; an idle ALU sees zero operands and an illegal op (no flags).
    always_comb begin
        alu_op_p0 = ALU_ILLEGAL;
        rs1_p0    = '0;
        rs2_p0    = '0;
        imm_p0    = '0;
        if (gnt_any) begin
            alu_op_p0 = alu_op_t'(req_op[gnt_idx]);
            rs1_p0    = req_rs1[gnt_idx];
            rs2_p0    = req_rs2[gnt_idx];
            imm_p0    = req_imm[gnt_idx];
        end
    end

    alu_op_decode u_decode (
        .op      (alu_op_p0),
        .sel     (sel_p0),
        .illegal (illegal_p0)
    );

    // Shared ALU: flags are one-hot, so no flag leaves the result at zero.
    always_comb begin
        opb_p0     = sel_p0.use_imm ? imm_p0 : rs2_p0;
        shamt_p0   = opb_p0[4:0];
        alu_res_p0 = '0;
        if (sel_p0.is_add || sel_p0.is_auipc || sel_p0.is_mem) alu_res_p0 = rs1_p0 + opb_p0;
        if (sel_p0.is_sub)  alu_res_p0 = rs1_p0 - opb_p0;
        if (sel_p0.is_sll)  alu_res_p0 = rs1_p0 << shamt_p0;
        if (sel_p0.is_srl)  alu_res_p0 = rs1_p0 >> shamt_p0;
        if (sel_p0.is_sra)  alu_res_p0 = $unsigned($signed(rs1_p0) >>> shamt_p0);
        if (sel_p0.is_slt)  alu_res_p0 = {31'b0, $signed(rs1_p0) < $signed(opb_p0)};
        if (sel_p0.is_sltu) alu_res_p0 = {31'b0, rs1_p0 < opb_p0};
        if (sel_p0.is_xor)  alu_res_p0 = rs1_p0 ^ opb_p0;
        if (sel_p0.is_or)   alu_res_p0 = rs1_p0 | opb_p0;
        if (sel_p0.is_and)  alu_res_p0 = rs1_p0 & opb_p0;
        if (sel_p0.is_beq)  alu_res_p0 = {31'b0, rs1_p0 == opb_p0};
        if (sel_p0.is_bne)  alu_res_p0 = {31'b0, rs1_p0 != opb_p0};
        if (sel_p0.is_blt)  alu_res_p0 = {31'b0, $signed(rs1_p0) < $signed(opb_p0)};
        if (sel_p0.is_bge)  alu_res_p0 = {31'b0, $signed(rs1_p0) >= $signed(opb_p0)};
        if (sel_p0.is_bltu) alu_res_p0 = {31'b0, rs1_p0 < opb_p0};
        if (sel_p0.is_bgeu) alu_res_p0 = {31'b0, rs1_p0 >= opb_p0};
    end

    // Round-robin pointer moves just past the winner; holds when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---- p0 -> p1: ALU result captured into the granted requester's slot ----
    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        logic             vld_p1;
        logic [31:0]      data_p1;
        logic [TAG_W-1:0] tag_p1;
        logic             err_p1;

        // Fill on grant (even while draining), empty on drain, otherwise hold.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_p1  <= 1'b0;
                data_p1 <= '0;
                tag_p1  <= '0;
                err_p1  <= 1'b0;
            end else if (req_ready[i]) begin
                vld_p1  <= 1'b1;
                data_p1 <= alu_res_p0;
                tag_p1  <= req_tag[i];
                err_p1  <= illegal_p0;
            end else if (rsp_ready[i]) begin
                vld_p1  <= 1'b0;
            end
        end

        assign rsp_valid[i] = vld_p1;
        assign rsp_data[i]  = data_p1;
        assign rsp_tag[i]   = tag_p1;
        assign rsp_err[i]   = err_p1;
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: scoreboard of expected responses plus directed checks.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int N  = 2;
    localparam int TW = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][5:0]     req_op;
    logic [N-1:0][31:0]    req_rs1;
    logic [N-1:0][31:0]    req_rs2;
    logic [N-1:0][31:0]    req_imm;
    logic [N-1:0][TW-1:0]  req_tag;
    logic [N-1:0]          rsp_valid;
    logic [N-1:0]          rsp_ready;
    logic [N-1:0][31:0]    rsp_data;
    logic [N-1:0][TW-1:0]  rsp_tag;
    logic [N-1:0]          rsp_err;

    typedef struct packed {
        logic [31:0]   data;
        logic [TW-1:0] tag;
        logic          err;
    } exp_t;

    exp_t        sb_q[N][$];
    int          gnt_log[$];
    int          errors = 0;
    int          checks = 0;
    logic        prev_rst = 1'b0;
    logic [N-1:0] prev_grant = '0;
    logic [N-1:0] prev_hold  = '0;
    logic [31:0]  prev_data[N];
    logic [TW-1:0] prev_tag[N];
    logic         prev_err[N];
    exp_t         exp_e;
    logic [32:0]  mres;

    alu_share_arb #(.N_REQ(N), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs1   (req_rs1),
        .req_rs2   (req_rs2),
        .req_imm   (req_imm),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference ALU: returns {err, data}.
    function automatic logic [32:0] model(input logic [5:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        logic [31:0] r;
        logic        e;
        r = 32'h0;
        e = 1'b0;
        case (op)
            ALU_AUIPC, ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW, ALU_ADDI: r = a + imm;
            ALU_BEQ:   r = (a == b) ? 32'd1 : 32'd0;
            ALU_BNE:   r = (a != b) ? 32'd1 : 32'd0;
            ALU_BLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_BGE:   r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            ALU_BLTU:  r = (a < b) ? 32'd1 : 32'd0;
            ALU_BGEU:  r = (a >= b) ? 32'd1 : 32'd0;
            ALU_SLTI:  r = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            ALU_SLTIU: r = (a < imm) ? 32'd1 : 32'd0;
            ALU_XORI:  r = a ^ imm;
            ALU_ORI:   r = a | imm;
            ALU_ANDI:  r = a & imm;
            ALU_SLLI:  r = a << imm[4:0];
            ALU_SRLI:  r = a >> imm[4:0];
            ALU_SRAI:  r = $unsigned($signed(a) >>> imm[4:0]);
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_SLL:   r = a << b[4:0];
            ALU_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:   r = a ^ b;
            ALU_SRL:   r = a >> b[4:0];
            ALU_SRA:   r = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:    r = a | b;
            ALU_AND:   r = a & b;
            default:   e = 1'b1;
        endcase
        return {e, r};
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic [TW-1:0] t);
        req_op[i]  = op;
        req_rs1[i] = a;
        req_rs2[i] = b;
        req_imm[i] = imm;
        req_tag[i] = t;
    endtask

    // Issue one op on requester 0 and check its response the following cycle.
    task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] imm,
                          input logic [31:0] exp_d, input logic exp_err);
        set_req(0, op, a, b, imm, 4'h5);
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        #4;
        check({nm, "_vld"},  rsp_valid[0], 1'b1);
        check({nm, "_data"}, rsp_data[0],  exp_d);
        check({nm, "_err"},  rsp_err[0],   exp_err);
        cyc();
    endtask

    // Monitor: sample mid-cycle, track handshakes, compare against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                check("rst_ready", req_ready, '0);
                if (prev_rst) check("rst_rsp_valid", rsp_valid, '0);
                for (int i = 0; i < N; i++) sb_q[i].delete();
                gnt_log.delete();
                prev_grant = '0;
                prev_hold  = '0;
                prev_rst   = 1'b1;
            end else begin
                if (prev_rst) check("post_rst_rsp_valid", rsp_valid, '0);
                check("grant_onehot", ($countones(req_ready) <= 1), 1'b1);
                for (int i = 0; i < N; i++) begin
                    if (prev_grant[i]) begin
                        check("latency_vld", rsp_valid[i], 1'b1);
                    end else if (prev_hold[i]) begin
                        check("hold_vld",  rsp_valid[i], 1'b1);
                        check("hold_data", rsp_data[i],  prev_data[i]);
                        check("hold_tag",  rsp_tag[i],   prev_tag[i]);
                        check("hold_err",  rsp_err[i],   prev_err[i]);
                    end
                    if (rsp_valid[i] && rsp_ready[i]) begin
                        if (sb_q[i].size() == 0) begin
                            check("sb_unexpected_rsp", 1'b1, 1'b0);
                        end else begin
                            exp_e = sb_q[i].pop_front();
                            check("sb_data", rsp_data[i], exp_e.data);
                            check("sb_tag",  rsp_tag[i],  exp_e.tag);
                            check("sb_err",  rsp_err[i],  exp_e.err);
                        end
                    end
                    if (req_valid[i] && req_ready[i]) begin
                        mres = model(req_op[i], req_rs1[i], req_rs2[i], req_imm[i]);
                        exp_e.data = mres[31:0];
                        exp_e.tag  = req_tag[i];
                        exp_e.err  = mres[32];
                        sb_q[i].push_back(exp_e);
                        gnt_log.push_back(i);
                    end
                    prev_data[i] = rsp_data[i];
                    prev_tag[i]  = rsp_tag[i];
                    prev_err[i]  = rsp_err[i];
                end
                prev_grant = req_valid & req_ready;
                prev_hold  = rsp_valid & ~rsp_ready;
                prev_rst   = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq_a[4];
        int exp_seq_b[4];
        exp_seq_a = '{0, 1, 0, 1};
        exp_seq_b = '{1, 0, 1, 0};

        // Reset with both requesters pushing.
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        set_req(0, ALU_ADD, 32'd1, 32'd2, 32'd0, 4'h1);
        set_req(1, ALU_SUB, 32'd9, 32'd4, 32'd0, 4'h2);
        cyc();
        cyc();
        rst = 1'b0;
        repeat (4) cyc();
        check("rst_grant_count", (gnt_log.size() >= 4), 1'b1);
        if (gnt_log.size() >= 4)
            for (int k = 0; k < 4; k++) check("rst_grant_order", gnt_log[k], exp_seq_a[k]);
        req_valid = 2'b00;
        repeat (2) cyc();

        // Single ADD on requester 0.
        set_req(0, ALU_ADD, 32'd5, 32'd7, 32'd0, 4'h3);
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        #4;
        check("single_vld",  rsp_valid[0], 1'b1);
        check("single_data", rsp_data[0],  32'd12);
        check("single_tag",  rsp_tag[0],   4'h3);
        check("single_err",  rsp_err[0],   1'b0);
        cyc();
        cyc();

        // Contention: rr_ptr sits at 1 after the single grant to requester 0.
        gnt_log.delete();
        set_req(0, ALU_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 4'h6);
        set_req(1, ALU_OR,  32'h1000, 32'h0001, 32'd0, 4'h7);
        req_valid = 2'b11;
        repeat (4) cyc();
        req_valid = 2'b00;
        check("cont_grant_count", (gnt_log.size() >= 4), 1'b1);
        if (gnt_log.size() >= 4)
            for (int k = 0; k < 4; k++) check("cont_grant_order", gnt_log[k], exp_seq_b[k]);
        repeat (2) cyc();

        // Backpressure on requester 0's response slot.
        set_req(0, ALU_SUB, 32'd10, 32'd3, 32'd0, 4'h1);
        set_req(1, ALU_AND, 32'hFF00, 32'h0FF0, 32'd0, 4'h2);
        req_valid = 2'b11;
        repeat (2) cyc();
        rsp_ready = 2'b10;
        repeat (4) cyc();
        #4;
        check("bp_rsp0_vld",   rsp_valid[0], 1'b1);
        check("bp_rsp0_data",  rsp_data[0],  32'd7);
        check("bp_ready_req1", req_ready,    2'b10);
        cyc();
        rsp_ready = 2'b11;
        #4;
        check("bp_release_ready", req_ready, 2'b01);
        cyc();
        req_valid = 2'b00;
        repeat (2) cyc();

        // Individual operations.
        run_op("sub",   ALU_SUB,  32'd0,        32'd1, 32'd0,        32'hFFFF_FFFF, 1'b0);
        run_op("sra",   ALU_SRA,  32'h8000_0000, 32'd4, 32'd0,       32'hF800_0000, 1'b0);
        run_op("blt",   ALU_BLT,  32'hFFFF_FFFF, 32'd1, 32'd0,       32'd1,         1'b0);
        run_op("bltu",  ALU_BLTU, 32'hFFFF_FFFF, 32'd1, 32'd0,       32'd0,         1'b0);
        run_op("lw",    ALU_LW,   32'h100,      32'd0, 32'hFFFF_FFFC, 32'hFC,       1'b0);
        run_op("auipc", ALU_AUIPC, 32'h1000,    32'd0, 32'h20,       32'h1020,      1'b0);
        run_op("slli",  ALU_SLLI, 32'd3,        32'd0, 32'd4,        32'h30,        1'b0);
        run_op("beq",   ALU_BEQ,  32'd5,        32'd5, 32'd0,        32'd1,         1'b0);
        run_op("ill0",  6'd0,     32'd5,        32'd6, 32'd7,        32'd0,         1'b1);
        run_op("ill63", 6'd63,    32'd5,        32'd6, 32'd7,        32'd0,         1'b1);

        // Reset while a response is pending.
        rsp_ready = 2'b00;
        set_req(0, ALU_ADD, 32'd1, 32'd1, 32'd0, 4'h9);
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        #4;
        check("pend_vld", rsp_valid[0], 1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        #4;
        check("rst_pend_cleared", rsp_valid, 2'b00);
        cyc();
        rst = 1'b0;
        repeat (3) cyc();
        #4;
        check("post_rst_idle", rsp_valid, 2'b00);
        cyc();

        rsp_ready = 2'b11;
        repeat (2) cyc();
        for (int i = 0; i < N; i++) check("sb_drained", sb_q[i].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
